// File: rtl/buffer_replay_ctrl.sv
// buffer_replay_ctrl: captures one tile into a single-port RAM while passing it
// through, then replays it from RAM R-1 more times via a 2-entry skid FIFO.
module buffer_replay_ctrl #(
   parameter  int DATA_WIDTH  = 32,
   parameter  int BUFFER_SIZE = 4,
   parameter  int MAX_REPEAT  = 16,
   localparam int RW = $clog2(MAX_REPEAT + 1),
   localparam int AW = $clog2(BUFFER_SIZE)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [RW-1:0]         cfg_repeat,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  data_in_valid,
   output logic                  data_in_ready,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_out_valid,
   input  logic                  data_out_ready,
   output logic [AW-1:0]         ram_addr,
   output logic                  ram_ce,
   output logic                  ram_we,
   output logic [DATA_WIDTH-1:0] ram_d,
   input  logic [DATA_WIDTH-1:0] ram_q,
   output logic                  busy,
   output logic                  done
);

   localparam int CW = $clog2((MAX_REPEAT - 1) * BUFFER_SIZE + 2);
   localparam logic [AW-1:0] LAST = AW'(BUFFER_SIZE - 1);
   localparam logic [RW-1:0] MAXR = RW'(MAX_REPEAT);

   typedef enum logic [1:0] {IDLE, FILL, REPLAY} state_e;

   state_e state_q, state_d;
   logic [RW-1:0] rep_q, rep_d, pass_q, pass_d;
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d, beat_q, beat_d;
   logic [CW-1:0] iss_q, iss_d, rd_total;
   logic          infl_q, infl_d;
   logic          done_q, done_d;
   logic [DATA_WIDTH-1:0] fifo_q [2];
   logic          wp_q, rp_q;
   logic [1:0]    cnt_q;
   logic          push, pop, flush;
   logic [RW-1:0] rep_sat;
   logic [2:0]    occ_after;

   assign rd_total  = (CW'(rep_q) - CW'(1)) * CW'(BUFFER_SIZE);
   assign rep_sat   = (cfg_repeat == '0)  ? RW'(1) :
                      (cfg_repeat > MAXR) ? MAXR : cfg_repeat;
   assign push      = infl_q;
   assign ram_d     = data_in;
   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   // a same-cycle pop frees a slot, which keeps replay bubble-free
   assign occ_after = {1'b0, cnt_q} + 3'(infl_q) - 3'(pop);

   always_comb begin
      state_d        = state_q;
      rep_d          = rep_q;
      pass_d         = pass_q;
      wr_d           = wr_q;
      rd_d           = rd_q;
      beat_d         = beat_q;
      iss_d          = iss_q;
      infl_d         = 1'b0;
      done_d         = 1'b0;
      flush          = 1'b0;
      pop            = 1'b0;
      cfg_ready      = 1'b0;
      data_in_ready  = 1'b0;
      data_out       = fifo_q[rp_q];
      data_out_valid = (cnt_q != 2'd0);
      ram_ce         = 1'b0;
      ram_we         = 1'b0;
      ram_addr       = '0;
      unique case (state_q)
         IDLE: begin
            cfg_ready      = 1'b1;
            data_out_valid = 1'b0;
            if (cfg_valid) begin
               rep_d   = rep_sat;
               wr_d    = '0;
               state_d = FILL;
            end
         end
         FILL: begin
            data_out       = data_in;
            data_out_valid = data_in_valid;
            data_in_ready  = data_out_ready;
            ram_addr       = wr_q;
            if (data_in_valid && data_out_ready) begin
               ram_ce = 1'b1;
               ram_we = 1'b1;
               wr_d   = (wr_q == LAST) ? '0 : wr_q + AW'(1);
               if (wr_q == LAST) begin
                  if (rep_q == RW'(1)) begin
                     state_d = IDLE;
                     done_d  = 1'b1;
                  end else begin
                     state_d = REPLAY;
                     rd_d    = '0;
                     beat_d  = '0;
                     iss_d   = '0;
                     pass_d  = RW'(2);
                  end
               end
            end
         end
         REPLAY: begin
            ram_addr = rd_q;
            pop      = (cnt_q != 2'd0) && data_out_ready;
            if (occ_after < 3'd2 && iss_q < rd_total) begin
               ram_ce = 1'b1;
               infl_d = 1'b1;
               iss_d  = iss_q + CW'(1);
               rd_d   = (rd_q == LAST) ? '0 : rd_q + AW'(1);
            end
            if (pop) begin
               beat_d = (beat_q == LAST) ? '0 : beat_q + AW'(1);
               if (beat_q == LAST) begin
                  pass_d = pass_q + RW'(1);
                  if (pass_q == rep_q) begin
                     state_d = IDLE;
                     done_d  = 1'b1;
                     flush   = 1'b1;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         rep_q   <= RW'(1);
         pass_q  <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         beat_q  <= '0;
         iss_q   <= '0;
         infl_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rep_q   <= rep_d;
         pass_q  <= pass_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         beat_q  <= beat_d;
         iss_q   <= iss_d;
         infl_q  <= infl_d;
         done_q  <= done_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fifo_q[0] <= '0;
         fifo_q[1] <= '0;
         wp_q      <= 1'b0;
         rp_q      <= 1'b0;
         cnt_q     <= 2'd0;
      end else if (flush) begin
         wp_q  <= 1'b0;
         rp_q  <= 1'b0;
         cnt_q <= 2'd0;
      end else begin
         if (push) begin
            fifo_q[wp_q] <= ram_q;
            wp_q         <= ~wp_q;
         end
         if (pop) rp_q <= ~rp_q;
         cnt_q <= cnt_q + 2'(push) - 2'(pop);
      end
   end

endmodule

// File: tb/tb_buffer_replay_ctrl.sv
// Scoreboard bench for buffer_replay_ctrl with a behavioural 1-cycle RAM.
// Expected beats/writes are queued by the stimulus and checked by a monitor.
module tb_buffer_replay_ctrl;

   localparam int DW = 32;
   localparam int BS = 4;
   localparam int MR = 16;
   localparam int RW = 5;
   localparam int AW = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [RW-1:0] cfg_repeat = '0;
   logic          cfg_valid = 1'b0;
   logic          cfg_ready;
   logic [DW-1:0] data_in = '0;
   logic          data_in_valid = 1'b0;
   logic          data_in_ready;
   logic [DW-1:0] data_out;
   logic          data_out_valid;
   logic          data_out_ready = 1'b1;
   logic [AW-1:0] ram_addr;
   logic          ram_ce, ram_we;
   logic [DW-1:0] ram_d;
   logic [DW-1:0] ram_q = '0;
   logic          busy, done;

   buffer_replay_ctrl #(
      .DATA_WIDTH(DW), .BUFFER_SIZE(BS), .MAX_REPEAT(MR)
   ) dut (
      .clk(clk), .rst(rst),
      .cfg_repeat(cfg_repeat), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .data_in(data_in), .data_in_valid(data_in_valid),
      .data_in_ready(data_in_ready),
      .data_out(data_out), .data_out_valid(data_out_valid),
      .data_out_ready(data_out_ready),
      .ram_addr(ram_addr), .ram_ce(ram_ce), .ram_we(ram_we),
      .ram_d(ram_d), .ram_q(ram_q),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] mem [BS];
   always @(posedge clk) begin
      if (ram_ce) begin
         if (ram_we) mem[ram_addr] <= ram_d;
         else        ram_q <= mem[ram_addr];
      end
   end

   int checks = 0, failures = 0;
   int outs = 0, reads = 0, writes = 0, dones = 0;
   int occ = 0, pend = 0, maxocc = 0;
   bit rnd_rdy = 1'b0;
   logic [DW-1:0] exp_q [$];
   int            wexp_a [$];
   logic [DW-1:0] wexp_d [$];

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   initial forever begin
      @(posedge clk); #1;
      data_out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   initial forever begin
      @(negedge clk);
      if (!rst) begin
         occ = 0; pend = 0;
      end else begin
         if (data_out_valid && data_out_ready) begin
            outs++;
            if (exp_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_beat actual=%0h required=none", data_out);
            end else chk("data_out", data_out, exp_q.pop_front());
         end
         if (ram_ce && ram_we) begin
            writes++;
            chk("we_only_on_hs", data_in_valid && data_in_ready, 1);
            if (wexp_a.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_write actual=%0h required=none", ram_addr);
            end else begin
               chk("wr_addr", ram_addr, wexp_a.pop_front());
               chk("wr_data", ram_d, wexp_d.pop_front());
            end
         end
         if (ram_ce && !ram_we) reads++;
         if (done) dones++;
         occ = occ + pend -
               int'(data_out_valid && data_out_ready && !data_in_ready && busy);
         if (occ > maxocc) maxocc = occ;
         pend = int'(ram_ce && !ram_we);
      end
   end

   task automatic check_reset();
      chk("rst_outs", {cfg_ready, data_in_ready, data_out_valid, ram_ce,
                       ram_we, busy, done}, 7'b1000000);
      chk("rst_addr", ram_addr, 0);
   endtask

   task automatic run_job(input int r_cfg, input int base, input bit rr,
                          input bit gaps, input bit poke, input int abort_at);
      int  reff, d0;
      bit  hs;
      reff = (r_cfg == 0) ? 1 : ((r_cfg > MR) ? MR : r_cfg);
      d0 = dones; reads = 0; writes = 0; maxocc = 0; outs = 0;
      rnd_rdy = rr;
      for (int p = 0; p < reff; p++)
         for (int i = 0; i < BS; i++) exp_q.push_back(DW'(base + i));
      for (int i = 0; i < BS; i++) begin
         wexp_a.push_back(i);
         wexp_d.push_back(DW'(base + i));
      end
      @(posedge clk); #1;
      cfg_repeat = RW'(r_cfg); cfg_valid = 1'b1;
      @(negedge clk);
      chk("cfg_ready_idle", cfg_ready, 1);
      @(posedge clk); #1;
      cfg_valid = 1'b0;
      chk("busy_after_cfg", busy, 1);
      for (int i = 0; i < BS; i++) begin
         if (gaps && (i % 2 == 1)) begin
            data_in_valid = 1'b0;
            repeat (2) begin @(posedge clk); #1; end
         end
         data_in = DW'(base + i); data_in_valid = 1'b1; hs = 1'b0;
         for (int c = 0; c < 200 && !hs; c++) begin
            @(negedge clk);
            hs = data_in_ready;
            @(posedge clk); #1;
         end
         data_in_valid = 1'b0;
         if (!hs) begin
            checks++; failures++;
            $display("FAIL fill_timeout actual=stalled required=handshake");
            return;
         end
         if (poke && i == 1) begin
            cfg_valid = 1'b1; cfg_repeat = RW'(2);
            @(negedge clk);
            chk("cfg_ready_fill", cfg_ready, 0);
            @(posedge clk); #1;
            cfg_valid = 1'b0;
         end
      end
      if (reff == 1) begin
         @(negedge clk);
         chk("done_timing", done, 1);
      end
      if (poke) begin
         repeat (3) @(posedge clk);
         #1; cfg_valid = 1'b1; cfg_repeat = RW'(9);
         @(negedge clk);
         chk("cfg_ready_replay", cfg_ready, 0);
         chk("busy_replay", busy, 1);
         @(posedge clk); #1;
         cfg_valid = 1'b0;
      end
      if (abort_at > 0) begin
         for (int c = 0; c < 200 && outs < abort_at; c++) begin
            @(posedge clk); #2;
         end
         chk("abort_reached", outs, abort_at);
         rst = 1'b0;
         #1;
         check_reset();
         exp_q.delete(); wexp_a.delete(); wexp_d.delete();
         repeat (2) @(posedge clk);
         #1;
         chk("no_done_abort", dones - d0, 0);
         rst = 1'b1;
         return;
      end
      for (int c = 0; c < 400 && dones == d0; c++) begin
         @(posedge clk); #2;
      end
      repeat (3) @(negedge clk);
      chk("done_once", dones - d0, 1);
      chk("beats_left", exp_q.size(), 0);
      chk("reads", reads, (reff - 1) * BS);
      chk("writes", writes, BS);
      chk("fifo_no_overflow", maxocc <= 2, 1);
      chk("idle_after", busy, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check_reset();
      rst = 1'b1;
      run_job(3, 'hA, 0, 0, 0, 0);
      run_job(1, 'h10, 0, 0, 0, 0);
      run_job(0, 'h20, 0, 0, 0, 0);
      run_job(4, 'h30, 1, 0, 0, 0);
      run_job(3, 'h40, 0, 0, 1, 0);
      run_job(2, 'h48, 0, 0, 0, 0);
      run_job(3, 'h50, 0, 0, 0, 5);
      run_job(2, 'h60, 0, 0, 0, 0);
      run_job(2, 'h70, 0, 1, 0, 0);
      run_job(20, 'h80, 0, 0, 0, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
